// File: rtl/pipe_stage_regs_pkg.sv
// pipe_stage_regs_pkg: MIPS opcode/func encodings, stage reset defaults and instruction-class decode.
package pipe_stage_regs_pkg;

   localparam logic [31:0] NOP_IR   = 32'h0000_0000;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BGEZALR = 6'b111111;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUBU    = 6'b100011;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_BGEZALR = 6'b000000;

   typedef enum logic [3:0] {
      I_NONE, I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_LUI,
      I_BEQ, I_J, I_JAL, I_JR, I_BGEZALR
   } instr_e;

   function automatic instr_e decode(input logic [31:0] ir);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      return (op == OP_RTYPE) ? ((fn == FN_ADDU) ? I_ADDU : (fn == FN_SUBU) ? I_SUBU :
                                 (fn == FN_JR) ? I_JR : I_NONE) :
             (op == OP_ORI) ? I_ORI : (op == OP_LW) ? I_LW : (op == OP_SW) ? I_SW :
             (op == OP_LUI) ? I_LUI : (op == OP_BEQ) ? I_BEQ : (op == OP_J) ? I_J :
             (op == OP_JAL) ? I_JAL :
             (op == OP_BGEZALR && fn == FN_BGEZALR) ? I_BGEZALR : I_NONE;
   endfunction

endpackage

// File: rtl/pipe_stage_regs_stage_reg.sv
// stage_reg: one pipeline stage IR+PC register pair with hold (en) and bubble (clr) controls.
module stage_reg
   import pipe_stage_regs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] ir_d,
   input  logic [31:0] pc_d,
   output logic [31:0] ir,
   output logic [31:0] pc
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ir <= NOP_IR;
         pc <= PC_RESET;
      end else if (en) begin
         ir <= ir_d;
         pc <= pc_d;
      end
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: F->D->E->M->W IR/PC register chain with Tuse/Tnew load-use and branch stall unit.
module pipe_stage_regs
   import pipe_stage_regs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] F_IR,
   input  logic [31:0] F_PC,
   output logic [31:0] D_IR,
   output logic [31:0] E_IR,
   output logic [31:0] M_IR,
   output logic [31:0] W_IR,
   output logic [31:0] D_PC,
   output logic [31:0] E_PC,
   output logic [31:0] M_PC,
   output logic [31:0] W_PC,
   output logic        stall,
   output logic        PC_en
);

   // a missing destination maps to $0, which never hazards
   function automatic logic [4:0] dest(input logic [31:0] ir);
      instr_e c;
      c = decode(ir);
      return (c inside {I_ADDU, I_SUBU, I_BGEZALR}) ? ir[15:11] :
             (c inside {I_ORI, I_LUI, I_LW}) ? ir[20:16] :
             (c == I_JAL) ? 5'd31 : 5'd0;
   endfunction

   function automatic logic [1:0] tnew_e(input logic [31:0] ir);
      instr_e c;
      c = decode(ir);
      return (c == I_LW) ? 2'd2 : (c inside {I_ADDU, I_SUBU, I_ORI}) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [1:0] tnew_m(input logic [31:0] ir);
      return (decode(ir) == I_LW) ? 2'd1 : 2'd0;
   endfunction

   // Tuse of 3 marks an operand that is not read; it can never be below any Tnew
   function automatic logic [1:0] tuse_rs(input logic [31:0] ir);
      instr_e c;
      c = decode(ir);
      return (c inside {I_BEQ, I_JR, I_BGEZALR}) ? 2'd0 :
             (c inside {I_ADDU, I_SUBU, I_ORI, I_LW, I_SW}) ? 2'd1 : 2'd3;
   endfunction

   function automatic logic [1:0] tuse_rt(input logic [31:0] ir);
      instr_e c;
      c = decode(ir);
      return (c inside {I_BEQ, I_BGEZALR}) ? 2'd0 :
             (c inside {I_ADDU, I_SUBU}) ? 2'd1 : (c == I_SW) ? 2'd2 : 2'd3;
   endfunction

   function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] dst, input logic [1:0] tnew);
      return (src != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   always_comb begin
      stall = hazard(D_IR[25:21], tuse_rs(D_IR), dest(E_IR), tnew_e(E_IR)) ||
              hazard(D_IR[20:16], tuse_rt(D_IR), dest(E_IR), tnew_e(E_IR)) ||
              hazard(D_IR[25:21], tuse_rs(D_IR), dest(M_IR), tnew_m(M_IR)) ||
              hazard(D_IR[20:16], tuse_rt(D_IR), dest(M_IR), tnew_m(M_IR));
   end

   assign PC_en = ~stall;

   stage_reg u_d (.clk(clk), .reset(reset), .en(~stall), .clr(1'b0),
                  .ir_d(F_IR), .pc_d(F_PC), .ir(D_IR), .pc(D_PC));
   stage_reg u_e (.clk(clk), .reset(reset), .en(1'b1), .clr(stall),
                  .ir_d(D_IR), .pc_d(D_PC), .ir(E_IR), .pc(E_PC));
   stage_reg u_m (.clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
                  .ir_d(E_IR), .pc_d(E_PC), .ir(M_IR), .pc(M_PC));
   stage_reg u_w (.clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
                  .ir_d(M_IR), .pc_d(M_PC), .ir(W_IR), .pc(W_PC));

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed hazard scenarios checked against a queue-style pipeline model plus literal pins.
module tb_pipe_stage_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] F_IR, F_PC;
   logic [31:0] D_IR, E_IR, M_IR, W_IR, D_PC, E_PC, M_PC, W_PC;
   logic        stall, PC_en;

   int total = 0;
   int bad = 0;
   int stalls = 0;
   logic [31:0] pc = 32'h0000_3000;

   logic [31:0] m_ir [4];
   logic [31:0] m_pc [4];
   logic        mvalid = 1'b0;

   pipe_stage_regs dut (
      .clk(clk), .reset(reset), .F_IR(F_IR), .F_PC(F_PC),
      .D_IR(D_IR), .E_IR(E_IR), .M_IR(M_IR), .W_IR(W_IR),
      .D_PC(D_PC), .E_PC(E_PC), .M_PC(M_PC), .W_PC(W_PC),
      .stall(stall), .PC_en(PC_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dst;
      int rs_use;
      int rt_use;
      int tnew;
   } info_t;

   // operand/result timing table; 99 = operand not read, dst -1 = no destination
   function automatic info_t info(input logic [31:0] ir);
      info_t i;
      i.dst = -1; i.rs_use = 99; i.rt_use = 99; i.tnew = 0;
      case (ir[31:26])
         6'h00: case (ir[5:0])
                   6'h21, 6'h23: begin i.dst = int'(ir[15:11]); i.rs_use = 1; i.rt_use = 1; i.tnew = 1; end
                   6'h08: i.rs_use = 0;
                   default: ;
                endcase
         6'h0d: begin i.dst = int'(ir[20:16]); i.rs_use = 1; i.tnew = 1; end
         6'h23: begin i.dst = int'(ir[20:16]); i.rs_use = 1; i.tnew = 2; end
         6'h2b: begin i.rs_use = 1; i.rt_use = 2; end
         6'h0f: i.dst = int'(ir[20:16]);
         6'h04: begin i.rs_use = 0; i.rt_use = 0; end
         6'h03: i.dst = 31;
         6'h3f: if (ir[5:0] == 6'h00) begin i.dst = int'(ir[15:11]); i.rs_use = 0; i.rt_use = 0; end
         default: ;
      endcase
      return i;
   endfunction

   function automatic logic model_stall();
      info_t d, x;
      int tn, rs, rt;
      logic s;
      s = 1'b0;
      d = info(m_ir[0]);
      rs = int'(m_ir[0][25:21]);
      rt = int'(m_ir[0][20:16]);
      for (int k = 1; k <= 2; k++) begin
         x = info(m_ir[k]);
         tn = (k == 1) ? x.tnew : ((x.tnew > 0) ? x.tnew - 1 : 0);
         if (x.dst > 0 && ((x.dst == rs && d.rs_use < tn) || (x.dst == rt && d.rt_use < tn)))
            s = 1'b1;
      end
      return s;
   endfunction

   // model pipeline: index 0..3 = D, E, M, W
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            m_ir[k] <= 32'h0;
            m_pc[k] <= 32'h3000;
         end
         mvalid <= 1'b1;
      end else begin
         if (model_stall()) begin
            m_ir[1] <= 32'h0;
            m_pc[1] <= 32'h3000;
         end else begin
            m_ir[0] <= F_IR;
            m_pc[0] <= F_PC;
            m_ir[1] <= m_ir[0];
            m_pc[1] <= m_pc[0];
         end
         m_ir[2] <= m_ir[1];
         m_pc[2] <= m_pc[1];
         m_ir[3] <= m_ir[2];
         m_pc[3] <= m_pc[2];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && stall) stalls++;
      if (mvalid) begin
         chk("D_IR", D_IR, m_ir[0]);
         chk("E_IR", E_IR, m_ir[1]);
         chk("M_IR", M_IR, m_ir[2]);
         chk("W_IR", W_IR, m_ir[3]);
         chk("D_PC", D_PC, m_pc[0]);
         chk("E_PC", E_PC, m_pc[1]);
         chk("M_PC", M_PC, m_pc[2]);
         chk("W_PC", W_PC, m_pc[3]);
         chk("stall", {31'b0, stall}, {31'b0, model_stall()});
         chk("PC_en", {31'b0, PC_en}, {31'b0, ~model_stall()});
      end
   end

   // present one fetched word and hold it until fetch is enabled at an edge
   task automatic issue(input logic [31:0] ir);
      int n;
      logic en;
      F_IR = ir;
      F_PC = pc;
      pc = pc + 32'd4;
      n = 0;
      forever begin
         @(negedge clk);
         en = PC_en;
         @(posedge clk);
         #1;
         if (en) break;
         n++;
         if (n > 8) begin
            chk("issue_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic seq(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input int n, input int exp, input string name);
      int s0;
      s0 = stalls;
      issue(a);
      if (n > 1) issue(b);
      if (n > 2) issue(c);
      repeat (4) issue(32'h0);
      chk(name, 32'(stalls - s0), 32'(exp));
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_D_IR"}, D_IR, 32'h0);
      chk({name, "_E_IR"}, E_IR, 32'h0);
      chk({name, "_M_IR"}, M_IR, 32'h0);
      chk({name, "_W_IR"}, W_IR, 32'h0);
      chk({name, "_D_PC"}, D_PC, 32'h3000);
      chk({name, "_W_PC"}, W_PC, 32'h3000);
      chk({name, "_stall"}, {31'b0, stall}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      F_IR = 32'h8C01_0000;
      F_PC = 32'h0000_1234;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      reset = 1'b0;

      // load-use: one stall, addu held in D, bubble into E
      issue(32'h8C01_0000);
      issue(32'h0021_1021);
      chk("lu_stall", {31'b0, stall}, 32'h1);
      chk("lu_pcen", {31'b0, PC_en}, 32'h0);
      chk("lu_D", D_IR, 32'h0021_1021);
      chk("lu_E", E_IR, 32'h8C01_0000);
      @(posedge clk);
      #1;
      chk("lu_bubble_E", E_IR, 32'h0);
      chk("lu_bubble_Epc", E_PC, 32'h3000);
      chk("lu_hold_D", D_IR, 32'h0021_1021);
      chk("lu_hold_Dpc", D_PC, pc - 32'd4);
      chk("lu_M", M_IR, 32'h8C01_0000);
      chk("lu_clear", {31'b0, stall}, 32'h0);
      repeat (4) issue(32'h0);

      seq(32'h8C01_0000, 32'h0021_1021, 32'h0, 2, 1, "load_use_stalls");
      seq(32'h3403_0005, 32'h1060_0001, 32'h0, 2, 1, "ori_beq_stalls");
      seq(32'h3403_0005, 32'h0, 32'h1060_0001, 3, 0, "ori_nop_beq_stalls");
      seq(32'h8C04_0000, 32'h0080_0008, 32'h0, 2, 2, "lw_jr_stalls");
      seq(32'h8C00_0000, 32'h0000_1021, 32'h0, 2, 0, "lw0_addu_stalls");
      seq(32'h8C05_0000, 32'hAC05_0000, 32'h0, 2, 0, "lw_sw_stalls");
      seq(32'h3C06_0001, 32'h10C0_0001, 32'h0, 2, 0, "lui_beq_stalls");
      seq(32'h0021_4021, 32'hFD00_4800, 32'h0, 2, 1, "addu_bgezalr_stalls");

      // reset during a load-use stall
      issue(32'h8C01_0000);
      issue(32'h0021_1021);
      chk("mid_pre_stall", {31'b0, stall}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state("mid_reset");
      reset = 1'b0;
      repeat (3) issue(32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
